// File: rtl/mdr_mem_interface.sv
// mdr_mem_interface: memory address/data register pair (MAR + MDR) with a
// single-word req/ack memory sequencer. MDR feeds the bus multiplexer.
// Every output is either a flop or a decode of the state register, so no
// input reaches an output without passing through a clock edge.

module mdr_mem_interface #(
  parameter int ADDR_W  = 9,   // MAR / memory address width
  parameter int TIMEOUT = 15   // wait cycles before an unanswered request aborts (1..255)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic              err_clr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       MDR_Bus_lines,
  output logic [ADDR_W-1:0] MAR_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  // Last counter value before the abort; the counter is 8 bits wide to
  // cover the full 1..255 range of TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] mdr;
  logic [ADDR_W-1:0] mar;

  logic waiting;
  logic ack_hit;
  logic tmo_hit;
  logic idle_load_ok;

  // Upper bus bits are not part of the address; collected here so they are
  // visibly consumed rather than silently dropped.
  logic bus_unused;
  assign bus_unused = ^BusMuxOut[31:ADDR_W];

  assign waiting = (state != IDLE);
  // An ack on the final wait edge wins over the timeout.
  assign ack_hit = waiting && mem_ack;
  assign tmo_hit = waiting && !mem_ack && (wait_cnt == CNT_LAST);
  // Registers accept bus loads only while no transaction is outstanding.
  assign idle_load_ok = (state == IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: Read has priority over Write; wait states leave on
  // ack or on timeout.
  // NOTE: the default assignment first guarantees every path drives
  // state_nxt, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Read)       state_nxt = RD_WAIT;
        else if (Write) state_nxt = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (ack_hit || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    busy   = 1'b0;
    mem_we = 1'b0;
    case (state)
      RD_WAIT: busy = 1'b1;
      WR_WAIT: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      default: ;
    endcase
  end

  // The request is exactly the wait phase: it rises with entry and drops
  // on the same edge that returns to IDLE.
  assign mem_req = busy;

  // Wait counter: parked at zero in IDLE, so each transaction starts from 0.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                                wait_cnt <= 8'd0;
    else if (!waiting || ack_hit || tmo_hit)  wait_cnt <= 8'd0;
    else                                      wait_cnt <= wait_cnt + 8'd1;
  end

  // MAR: loads in IDLE; a same-cycle Read/Write then uses the new address.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                       mar <= '0;
    else if (idle_load_ok && MARin)  mar <= BusMuxOut[ADDR_W-1:0];
  end

  // MDR: captures read data on a read ack, or the bus in IDLE unless a read
  // is starting (the read will overwrite it anyway).
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                                   mdr <= '0;
    else if (ack_hit && (state == RD_WAIT))      mdr <= mem_rdata;
    else if (idle_load_ok && MDRin && !Read)     mdr <= BusMuxOut;
  end

  // Completion pulse for the cycle after the transaction ends.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) done <= 1'b0;
    else       done <= ack_hit || tmo_hit;
  end

  // Sticky abort flag; a new timeout beats a simultaneous clear request.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)        timeout_err <= 1'b0;
    else if (tmo_hit) timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

  assign MDR_Bus_lines = mdr;
  assign mem_wdata     = mdr;
  assign MAR_addr      = mar;
  assign mem_addr      = mar;

endmodule
